// File: rtl/rv32i_control_fsm.sv
// rv32i_control_fsm
// Multicycle sequencer for the RV32I datapath plus the boot-load path that
// streams loader words into the datapath flash write port.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | waiting for a load session (priority) or start
// S_LOAD       | accepting loader beats into flash until ld_req drops
// S_FETCH      | PC addresses memory; halt_req is honoured here only
// S_FETCH_LATCH| read data valid, latch IR and advance PC
// S_DECODE     | opcode valid from IR, branch on instruction class
// S_EXEC_R     | R-type writeback from ALU, retires
// S_MEM_ADDR   | data address from instr[31:20] drives memory
// S_LOAD_WB    | memory read data written to regfile, retires
// S_STORE      | memory write, retires
// S_TRAP       | unsupported opcode seen; only reset leaves
module rv32i_control_fsm #(
    parameter int WIDTH       = 32,
    parameter int FLASH_WORDS = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_halt_req,
    input  logic [6:0]       i_opcode,
    input  logic             i_ld_req,
    input  logic             i_ld_valid,
    input  logic [WIDTH-1:0] i_ld_data,
    output logic             o_ld_ready,
    output logic             o_regfile_wren,
    output logic             o_ir_wren,
    output logic             o_pc_inc,
    output logic             o_mem_wren,
    output logic             o_regfile_load_from_mem,
    output logic             o_ram_raddr_31_20,
    output logic             o_flash_en,
    output logic [WIDTH-1:0] o_flash_addr,
    output logic [WIDTH-1:0] o_flash_data,
    output logic             o_busy,
    output logic             o_illegal_op,
    output logic [WIDTH-1:0] o_instret
);

    // One extra bit so the counter can hold FLASH_WORDS itself (session full).
    localparam int            CW   = $clog2(FLASH_WORDS) + 1;
    localparam logic [CW-1:0] FULL = CW'(FLASH_WORDS);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_FETCH_LATCH,
        S_DECODE,
        S_EXEC_R,
        S_MEM_ADDR,
        S_LOAD_WB,
        S_STORE,
        S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic             r_flash_en;
    logic [WIDTH-1:0] r_flash_addr;
    logic [WIDTH-1:0] r_flash_data;
    logic [WIDTH-1:0] r_instret;
    logic             r_illegal_op;
    logic             w_accept;
    logic             w_retire;
    logic             w_illegal_dec;

    assign w_accept      = o_ld_ready && i_ld_valid;
    assign w_retire      = (r_state == S_EXEC_R) || (r_state == S_LOAD_WB) || (r_state == S_STORE);
    assign w_illegal_dec = (r_state == S_DECODE) && (w_next == S_TRAP);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_ld_req) begin
                    w_next = S_LOAD;
                end else if (i_start) begin
                    w_next = S_FETCH;
                end
            end
            S_LOAD:        if (!i_ld_req) w_next = S_IDLE;
            S_FETCH:       w_next = i_halt_req ? S_IDLE : S_FETCH_LATCH;
            S_FETCH_LATCH: w_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OPC_OP:    w_next = S_EXEC_R;
                    OPC_LOAD:  w_next = S_MEM_ADDR;
                    OPC_STORE: w_next = S_STORE;
                    default:   w_next = S_TRAP;
                endcase
            end
            S_EXEC_R:      w_next = S_FETCH;
            S_MEM_ADDR:    w_next = S_LOAD_WB;
            S_LOAD_WB:     w_next = S_FETCH;
            S_STORE:       w_next = S_FETCH;
            S_TRAP:        w_next = S_TRAP;
            default:       w_next = S_IDLE;
        endcase
    end

    // Moore control outputs decoded from the state register.
    always_comb begin
        o_regfile_wren          = 1'b0;
        o_ir_wren               = 1'b0;
        o_pc_inc                = 1'b0;
        o_mem_wren              = 1'b0;
        o_regfile_load_from_mem = 1'b0;
        o_ram_raddr_31_20       = 1'b0;
        o_ld_ready              = 1'b0;
        o_busy                  = (r_state != S_IDLE) && (r_state != S_TRAP);
        case (r_state)
            S_LOAD:        o_ld_ready = (r_count < FULL);
            S_FETCH_LATCH: begin
                o_ir_wren = 1'b1;
                o_pc_inc  = 1'b1;
            end
            S_EXEC_R:      o_regfile_wren = 1'b1;
            S_MEM_ADDR:    o_ram_raddr_31_20 = 1'b1;
            S_LOAD_WB: begin
                o_ram_raddr_31_20       = 1'b1;
                o_regfile_load_from_mem = 1'b1;
                o_regfile_wren          = 1'b1;
            end
            S_STORE: begin
                o_ram_raddr_31_20 = 1'b1;
                o_mem_wren        = 1'b1;
            end
            default: ;
        endcase
    end

    // Loader beat capture; a beat offered as ld_req drops still lands, but
    // the session counter restarts from zero for the next session.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count      <= '0;
            r_flash_en   <= 1'b0;
            r_flash_addr <= '0;
            r_flash_data <= '0;
        end else begin
            r_flash_en <= w_accept;
            if (w_accept) begin
                r_flash_addr <= WIDTH'(r_count) << 2;
                r_flash_data <= i_ld_data;
            end
            if ((r_state == S_LOAD) && !i_ld_req) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Retired-instruction counter and sticky illegal-opcode flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_instret    <= '0;
            r_illegal_op <= 1'b0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + WIDTH'(1);
            end
            if (w_illegal_dec) begin
                r_illegal_op <= 1'b1;
            end
        end
    end

    assign o_flash_en   = r_flash_en;
    assign o_flash_addr = r_flash_addr;
    assign o_flash_data = r_flash_data;
    assign o_instret    = r_instret;
    assign o_illegal_op = r_illegal_op;

endmodule

// File: doc/rv32i_control_fsm.md
Name: rv32i_control_fsm

Overview:
Multicycle sequencer for the RV32I datapath. It drives the datapath's register enables, write enable and mux selects from the decoded opcode, and runs fetch / decode / execute / writeback. It also owns the boot-load path: it accepts a word stream from an external loader and presents it to the datapath's flash write port. It sits beside the datapath in the top level and is the only driver of its control inputs.

Parameters:
WIDTH, 32, datapath word width; also the width of flash_addr, flash_data and instret.
FLASH_WORDS, 256, maximum words accepted per load session; power of two, at least 2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  begin execution from IDLE (level, sampled in IDLE only)
halt_req  input  1  stop at the next instruction boundary
opcode  input  7  rv32i_opcode_t from the datapath instruction register
ld_req  input  1  loader requests a load session (level)
ld_valid  input  1  loader data beat valid
ld_data  input  WIDTH  loader data word
ld_ready  output  1  controller accepts a beat this cycle
regfile_wren, ir_wren, pc_inc, mem_wren  output  1 each  datapath enables
regfile_load_from_mem, ram_raddr_31_20  output  1 each  datapath mux selects
flash_en  output  1  datapath flash write strobe
flash_addr  output  WIDTH  byte address of the flash write
flash_data  output  WIDTH  flash write data
busy  output  1  state is not IDLE and not TRAP
illegal_op  output  1  sticky: an unsupported opcode was decoded
instret  output  WIDTH  count of retired instructions

Behaviour:
- Reset (async, rst=1): state=IDLE; every output 0; load word counter=0; instret=0; illegal_op=0.
- States: IDLE, LOAD, FETCH, FETCH_LATCH, DECODE, EXEC_R, MEM_ADDR, LOAD_WB, STORE, TRAP. Each state lasts exactly 1 cycle except IDLE, LOAD and TRAP.
- Control outputs are Moore functions of the state (decoded from the state register). Any signal not listed for a state is 0.
- IDLE:
  - ld_req=1 goes to LOAD. This has priority over start.
  - Else start=1 goes to FETCH.
- FETCH: ram_raddr_31_20=0 (the PC addresses memory). Next state is FETCH_LATCH.
  - If halt_req=1 on entry, go to IDLE instead. halt_req is honoured only here.
- FETCH_LATCH: ir_wren=1, pc_inc=1. Memory has 1-cycle read latency, so read data is valid here. Next state is DECODE.
- DECODE: opcode is valid from the IR. Transitions:
  - 7'b0110011 (OP) goes to EXEC_R.
  - 7'b0000011 (LOAD) goes to MEM_ADDR.
  - 7'b0100011 (STORE) goes to STORE.
  - Anything else goes to TRAP and sets illegal_op=1.
- EXEC_R: regfile_wren=1, regfile_load_from_mem=0. Retires. Next state is FETCH.
- MEM_ADDR: ram_raddr_31_20=1. Next state is LOAD_WB.
- LOAD_WB: ram_raddr_31_20=1, regfile_load_from_mem=1, regfile_wren=1. Retires. Next state is FETCH.
- STORE: ram_raddr_31_20=1, mem_wren=1. Retires. Next state is FETCH.
- Retire: instret increments by 1 on the clock edge leaving EXEC_R, LOAD_WB or STORE. It wraps from all-ones to 0.
- TRAP: all enables 0; busy=0. Only rst leaves TRAP. start and ld_req are ignored.
- Latency per instruction: R-type 4 cycles, load 5 cycles, store 4 cycles (counted from FETCH).
- LOAD state:
  - ld_ready = (count < FLASH_WORDS).
  - A beat is accepted when ld_valid && ld_ready.
  - On the next clock: flash_en=1 (1-cycle pulse), flash_data=ld_data, flash_addr=count*4, then count increments. flash_en/addr/data are registered.
  - flash_addr and flash_data hold their value between beats. flash_en is 0 when no beat was accepted.
  - Once count=FLASH_WORDS: ld_ready=0 and further beats are dropped; this is not an error.
  - ld_req=0 returns to IDLE and clears count. A beat presented in that same cycle is still accepted if ld_ready=1.
  - Back-to-back beats every cycle are supported.
- All datapath enables are 0 in LOAD, so the CPU does not run during a load.
- rst mid-instruction or mid-load aborts immediately with reset values. Partially loaded memory contents are left as-is.

Test Plan:
- rst pulse mid-EXEC_R -> every output 0 while rst=1; after release, IDLE with busy=0, instret=0.
- ld_req=1; 3 beats 0xDEADBEEF, 0x00000013, 0x12345678 on consecutive cycles -> flash_en pulses on 3 consecutive cycles; addr 0x0, 0x4, 0x8 with matching data; count cleared after ld_req=0.
- FLASH_WORDS=4; 6 beats offered -> ld_ready drops after the 4th beat; exactly 4 flash_en pulses; last addr 0xC.
- start with opcode 0x33 at DECODE -> FETCH, FETCH_LATCH (ir_wren=pc_inc=1), DECODE, EXEC_R (regfile_wren=1); instret=1 after 4 cycles.
- Sequence LOAD (0x03) then STORE (0x23) -> LOAD_WB asserts ram_raddr_31_20=regfile_load_from_mem=regfile_wren=1; STORE asserts mem_wren=1, ram_raddr_31_20=1; instret=2 after 9 cycles.
- opcode 0x7F at DECODE -> TRAP; illegal_op=1, busy=0; start ignored for 10 cycles; rst clears illegal_op.
- halt_req asserted during EXEC_R -> next FETCH goes to IDLE with no ir_wren; instret is unchanged afterwards.
